// File: rtl/fifo_pkg.sv
// Shared definitions for the sync-FIFO read-side adapter: legal read latencies,
// occupancy state encoding and queue sizing helpers.
package fifo_pkg;

  localparam int unsigned RDLAT_COMB = 0;
  localparam int unsigned RDLAT_REG  = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;

  // One slot per cycle of read latency plus two, so reads can be issued
  // from registered state alone without starving a ready consumer.
  function automatic int unsigned qdepth(input int unsigned lat);
    return lat + 2;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the adapter.
// master = adapter side, slave = FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_stream_q.sv
// DEPTH-entry circular queue with registered occupancy state; head entry is
// presented directly from the storage array.
module fifo_rd_stream_q
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned OCC_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [OCC_W-1:0]      o_occ,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [OCC_W-1:0]      r_occ;
  occ_state_t            r_state;

  logic                  w_pop;
  logic [OCC_W-1:0]      w_occ_nxt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = i_pop && (r_state != OCC_EMPTY);

  always_comb begin
    w_occ_nxt = r_occ;
    if (i_push && !w_pop) begin
      w_occ_nxt = r_occ + 1'b1;
    end else if (!i_push && w_pop) begin
      w_occ_nxt = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_state <= OCC_EMPTY;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      r_occ <= w_occ_nxt;
      if (w_occ_nxt == '0) begin
        r_state <= OCC_EMPTY;
      end else if (w_occ_nxt == OCC_W'(DEPTH)) begin
        r_state <= OCC_FULL;
      end else begin
        r_state <= OCC_PARTIAL;
      end
    end
  end

  assign o_occ       = r_occ;
  assign o_valid     = (r_state != OCC_EMPTY);
  assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pulls words from a sync FIFO (read latency 0 or 1) and
// re-presents them as a bubble-free valid/ready stream. Define
// FIFO_RD_STREAM_CNT_EN to add the xfer_cnt delivered-word counter port.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = RDLAT_COMB,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_rd_stream_if.master     bus
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

  localparam int unsigned DEPTH = qdepth(RD_LATENCY);
  localparam int unsigned OCC_W = ptr_w(DEPTH + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  if ((RD_LATENCY != RDLAT_COMB && RD_LATENCY != RDLAT_REG) || CNT_WIDTH == 0) begin : g_bad_cfg
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1 and CNT_WIDTH nonzero");
  end

  logic [OCC_W-1:0]      w_occ;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_inflight;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [SUM_W-1:0]      w_credit_used;

  assign w_pop = w_valid && bus.m_ready;

  // Reads are credited against registered occupancy only, so m_ready never
  // reaches fifo_rd_en; the extra queue slot hides the pop we cannot see.
  assign w_credit_used = SUM_W'(w_occ) + SUM_W'(w_inflight);
  assign w_rd_en       = !rst && !bus.fifo_empty && (w_credit_used < SUM_W'(DEPTH));

  if (RD_LATENCY == RDLAT_REG) begin : g_reg
    logic r_inflight;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_rd_en;
      end
    end
    assign w_inflight = r_inflight;
    assign w_push     = r_inflight;
  end else begin : g_comb
    assign w_inflight = 1'b0;
    assign w_push     = w_rd_en;
  end

  fifo_rd_stream_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .OCC_W      (OCC_W)
  ) u_q (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (bus.fifo_rd_data),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_valid     (w_valid),
    .o_head_data (w_head)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_xfer_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end
  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: latency-0 and latency-1 instances driven side by side
// from behavioural sync-FIFO models, with a per-instance scoreboard on the stream.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) if0 ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) if1 ();

  logic          empty_v [2];
  logic [DW-1:0] rdd_v   [2];
  logic          rdy_v   [2];
  logic          rden_s  [2];
  logic          rd_en_w [2];
  logic          mv_w    [2];
  logic [DW-1:0] md_w    [2];

  logic [DW-1:0] fq [2][$];
  logic [DW-1:0] sb [2][$];
  int            pops [2];

  int checks   = 0;
  int failures = 0;

  assign if0.fifo_empty   = empty_v[0];
  assign if0.fifo_rd_data = rdd_v[0];
  assign if0.m_ready      = rdy_v[0];
  assign if1.fifo_empty   = empty_v[1];
  assign if1.fifo_rd_data = rdd_v[1];
  assign if1.m_ready      = rdy_v[1];
  assign rd_en_w[0] = if0.fifo_rd_en;
  assign rd_en_w[1] = if1.fifo_rd_en;
  assign mv_w[0]    = if0.m_valid;
  assign mv_w[1]    = if1.m_valid;
  assign md_w[0]    = if0.m_data;
  assign md_w[1]    = if1.m_data;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [3:0] cnt0, cnt1;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(0), .CNT_WIDTH(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .xfer_cnt (cnt0)
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .xfer_cnt (cnt1)
`endif
  );

  typedef struct {
    logic          rdy;
    logic          rden;
    logic          v0;
    logic [DW-1:0] d0;
    logic          c0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          c1;
  } row_t;

  row_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 2; i++) empty_v[i] = (fq[i].size() == 0);
    rdd_v[0] = (fq[0].size() != 0) ? fq[0][0] : '0;
  endtask

  task automatic fifo_write(input logic [DW-1:0] x);
    for (int i = 0; i < 2; i++) begin
      fq[i].push_back(x);
      sb[i].push_back(x);
    end
    refresh();
  endtask

  // Called at the negedge: protocol check and scoreboard compare on pops.
  task automatic monitor();
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_en_while_empty_l%0d", i), 32'(rd_en_w[i] & empty_v[i]), 32'(0));
      rden_s[i] = rd_en_w[i];
      if (mv_w[i] === 1'b1 && rdy_v[i]) begin
        pops[i]++;
        if (sb[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word_l%0d: got 0x%0h expected no word", i, md_w[i]);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("data_l%0d", i), 32'(md_w[i]), 32'(e));
        end
      end
    end
  endtask

  // FIFO model updates just after the edge at which the DUT sampled it.
  task automatic advance();
    logic          rst_s;
    logic [DW-1:0] w;
    rst_s = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst_s) begin
        fq[i].delete();
        sb[i].delete();
        pops[i] = 0;
        if (i == 1) rdd_v[1] = '0;
      end else if (rden_s[i] && fq[i].size() != 0) begin
        w = fq[i].pop_front();
        if (i == 1) rdd_v[1] = w;
      end
    end
    refresh();
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    advance();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_left_l0"}, 32'(sb[0].size()), 32'(0));
    chk({name, "_left_l1"}, 32'(sb[1].size()), 32'(0));
  endtask

  initial begin
    int first [2];
    int last  [2];
    int nval  [2];
    int nw;
    int cyc;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rdy_v[i]  = 1'b1;
      rden_s[i] = 1'b0;
      rdd_v[i]  = '0;
      pops[i]   = 0;
    end
    refresh();

    // Reset state
    advance();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid_l%0d", i), 32'(mv_w[i]), 32'(0));
      chk($sformatf("rst_data_l%0d", i), 32'(md_w[i]), 32'(0));
      chk($sformatf("rst_rd_en_l%0d", i), 32'(rd_en_w[i]), 32'(0));
    end
    monitor();
    advance();
    rst = 1'b0;
    tick();

    // Preloaded three words, consumer always ready; one row per cycle
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    for (int r = 0; r < 6; r++) begin
      rdy_v[0] = tbl[r].rdy;
      rdy_v[1] = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("t1_rd_en_l0_c%0d", r), 32'(rd_en_w[0]), 32'(tbl[r].rden));
      chk($sformatf("t1_rd_en_l1_c%0d", r), 32'(rd_en_w[1]), 32'(tbl[r].rden));
      chk($sformatf("t1_valid_l0_c%0d", r), 32'(mv_w[0]), 32'(tbl[r].v0));
      chk($sformatf("t1_valid_l1_c%0d", r), 32'(mv_w[1]), 32'(tbl[r].v1));
      if (tbl[r].c0) chk($sformatf("t1_data_l0_c%0d", r), 32'(md_w[0]), 32'(tbl[r].d0));
      if (tbl[r].c1) chk($sformatf("t1_data_l1_c%0d", r), 32'(md_w[1]), 32'(tbl[r].d1));
      monitor();
      advance();
    end
    drain("t1", 4);
    tick();

    // 16 words: first beat lat+1 cycles after empty falls, then back-to-back
    for (int w = 0; w < 16; w++) fifo_write(8'(w));
    for (int i = 0; i < 2; i++) begin
      first[i] = -1;
      last[i]  = -1;
      nval[i]  = 0;
    end
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mv_w[i] === 1'b1) begin
          if (first[i] < 0) first[i] = c;
          last[i] = c;
          nval[i]++;
        end
      end
      monitor();
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t2_first_l%0d", i), 32'(first[i]), 32'(i + 1));
      chk($sformatf("t2_beats_l%0d", i), 32'(nval[i]), 32'(16));
      chk($sformatf("t2_last_l%0d", i), 32'(last[i]), 32'(i + 16));
    end
    drain("t2", 4);

    // Consumer stalled 10 cycles with five words queued in the FIFO
    rdy_v[0] = 1'b0;
    rdy_v[1] = 1'b0;
    for (int w = 0; w < 5; w++) fifo_write(8'h50 + 8'(w));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("t3_valid_l%0d_c%0d", i, c), 32'(mv_w[i]), 32'(1));
          chk($sformatf("t3_hold_l%0d_c%0d", i, c), 32'(md_w[i]), 32'(8'h50));
        end
      end
      if (c >= 4) begin
        chk($sformatf("t3_rd_en_l0_c%0d", c), 32'(rd_en_w[0]), 32'(0));
        chk($sformatf("t3_rd_en_l1_c%0d", c), 32'(rd_en_w[1]), 32'(0));
      end
      monitor();
      advance();
    end
    chk("t3_fifo_left_l0", 32'(fq[0].size()), 32'(5 - qdepth(0)));
    chk("t3_fifo_left_l1", 32'(fq[1].size()), 32'(5 - qdepth(1)));
    rdy_v[0] = 1'b1;
    rdy_v[1] = 1'b1;
    drain("t3", 12);

    // Random ready and random FIFO writes, 1000 words
    nw  = 0;
    cyc = 0;
    while ((nw < 1000 || sb[0].size() != 0 || sb[1].size() != 0) && cyc < 8000) begin
      rdy_v[0] = 1'($urandom_range(0, 1));
      rdy_v[1] = 1'($urandom_range(0, 1));
      if (nw < 1000 && $urandom_range(0, 1) == 1) begin
        fifo_write(8'($urandom));
        nw++;
      end
      tick();
      cyc++;
    end
    chk("t4_words_written", 32'(nw), 32'(1000));
    chk("t4_left_l0", 32'(sb[0].size()), 32'(0));
    chk("t4_left_l1", 32'(sb[1].size()), 32'(0));
    rdy_v[0] = 1'b1;
    rdy_v[1] = 1'b1;
    tick();

    // Reset while the latency-1 instance holds two words and one in flight
    rdy_v[0] = 1'b0;
    rdy_v[1] = 1'b0;
    for (int w = 0; w < 5; w++) fifo_write(8'h70 + 8'(w));
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rd_en_in_rst_l0", 32'(rd_en_w[0]), 32'(0));
    chk("t5_rd_en_in_rst_l1", 32'(rd_en_w[1]), 32'(0));
    monitor();
    advance();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t5_valid_l%0d", i), 32'(mv_w[i]), 32'(0));
      chk($sformatf("t5_data_l%0d", i), 32'(md_w[i]), 32'(0));
      chk($sformatf("t5_rd_en_l%0d", i), 32'(rd_en_w[i]), 32'(0));
    end
    monitor();
    advance();
    rdy_v[0] = 1'b1;
    rdy_v[1] = 1'b1;
    fifo_write(8'hA5);
    @(negedge clk);
    chk("t5_first_rd_en_l0", 32'(rd_en_w[0]), 32'(1));
    chk("t5_first_rd_en_l1", 32'(rd_en_w[1]), 32'(1));
    monitor();
    advance();
    drain("t5", 8);
    chk("t5_pops_l0", 32'(pops[0]), 32'(1));
    chk("t5_pops_l1", 32'(pops[1]), 32'(1));

    // 18 pops after a fresh reset; a 4-bit counter wraps to 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 18; w++) fifo_write(8'hC0 + 8'(w));
    drain("t6", 40);
    tick();
    chk("t6_pops_l0", 32'(pops[0]), 32'(18));
    chk("t6_pops_l1", 32'(pops[1]), 32'(18));
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("t6_xfer_cnt_l0", 32'(cnt0), 32'(2));
    chk("t6_xfer_cnt_l1", 32'(cnt1), 32'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
